// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package countdown_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

  // Counter width for a modulus-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/countdown_core_bcd_mod60.sv
// Two-digit BCD mod-60 field (00..59) with increment, decrement and clear.
// Latency: one cycle; next-value outputs let the parent register derived flags.
// Backpressure: none; each control is consumed in the cycle it is asserted.
module bcd_mod60
  import countdown_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tens_nxt,
  output logic [3:0] ones_nxt,
  output logic       zero,
  output logic       borrow
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Next field value: clear beats increment beats decrement; 59->00 and 00->59 wrap.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    borrow = 1'b0;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (ones_q == DIGIT_MAX_ONES) begin
        ones_d = 4'd0;
        tens_d = (tens_q == DIGIT_MAX_TENS) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec) begin
      if (ones_q == 4'd0) begin
        ones_d = DIGIT_MAX_ONES;
        if (tens_q == 4'd0) begin
          tens_d = DIGIT_MAX_TENS;
          borrow = 1'b1;
        end else begin
          tens_d = tens_q - 4'd1;
        end
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // Field storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign tens_nxt = tens_d;
  assign ones_nxt = ones_d;
  assign zero     = (tens_q == 4'd0) && (ones_q == 4'd0);

endmodule

// File: rtl/countdown_core.sv
// MM:SS countdown timekeeping core with SET/RUN/PAUSE/DONE control and display enables.
// Latency: one cycle from a button pulse to every (registered) output.
// Backpressure: none; pulses are acted on in the cycle they arrive or dropped by priority.
module countdown_core
  import countdown_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pause,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       clear,
  output logic [3:0] digit_3,
  output logic [3:0] digit_2,
  output logic [3:0] digit_1,
  output logic [3:0] digit_0,
  output logic       enable_3,
  output logic       enable_2,
  output logic       enable_1,
  output logic       enable_0,
  output logic       running,
  output logic       done
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    en_q, en_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic       fld_clr, sec_inc, min_inc, sec_dec;
  logic       sec_borrow, min_borrow_unused;
  logic       sec_zero, min_zero;
  logic [3:0] sec_tens_nxt, sec_ones_nxt, min_tens_nxt, min_ones_nxt;
  logic       tick, blink_wrap, time_zero, time_zero_nxt, min_nz_nxt;

  assign tick       = (presc_q == TICK_LAST);
  assign blink_wrap = (blink_q == BLINK_LAST);
  assign time_zero  = sec_zero && min_zero;

  // Field controls: clear and start_pause mask the lower-priority actions.
  assign fld_clr = clear || ((state_q == DONE) && start_pause);
  assign sec_inc = (state_q == SET) && inc_sec && !clear && !start_pause;
  assign min_inc = (state_q == SET) && inc_min && !clear && !start_pause;
  assign sec_dec = (state_q == RUN) && tick && !clear && !start_pause;

  assign time_zero_nxt = (sec_tens_nxt == 4'd0) && (sec_ones_nxt == 4'd0) &&
                         (min_tens_nxt == 4'd0) && (min_ones_nxt == 4'd0);
  assign min_nz_nxt    = (min_tens_nxt != 4'd0);

  bcd_mod60 u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fld_clr),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .tens     (digit_1),
    .ones     (digit_0),
    .tens_nxt (sec_tens_nxt),
    .ones_nxt (sec_ones_nxt),
    .zero     (sec_zero),
    .borrow   (sec_borrow)
  );

  // Minutes never borrow: the countdown stops at 00:00 before they could.
  bcd_mod60 u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fld_clr),
    .inc      (min_inc),
    .dec      (sec_borrow),
    .tens     (digit_3),
    .ones     (digit_2),
    .tens_nxt (min_tens_nxt),
    .ones_nxt (min_ones_nxt),
    .zero     (min_zero),
    .borrow   (min_borrow_unused)
  );

  // Control next-state, prescaler/blink counters, and the registered display flags.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blink_d = blink_q;
    phase_d = phase_q;
    case (state_q)
      SET: begin
        if (start_pause && !time_zero) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (start_pause) begin
          state_d = PAUSE;
          blink_d = '0;
          phase_d = 1'b1;
        end else if (tick) begin
          presc_d = '0;
          if (time_zero_nxt) begin
            state_d = DONE;
            blink_d = '0;
            phase_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        if (start_pause) begin
          state_d = RUN;
        end else begin
          blink_d = blink_wrap ? '0 : blink_q + 1'b1;
          phase_d = phase_q ^ blink_wrap;
        end
      end
      DONE: begin
        if (start_pause) begin
          state_d = SET;
        end else begin
          blink_d = blink_wrap ? '0 : blink_q + 1'b1;
          phase_d = phase_q ^ blink_wrap;
        end
      end
      default: state_d = SET;
    endcase
    if (clear) begin
      state_d = SET;
      presc_d = '0;
      blink_d = '0;
      phase_d = 1'b1;
    end

    case (state_d)
      RUN:     en_d = {min_nz_nxt, 3'b111};
      PAUSE:   en_d = phase_d ? {min_nz_nxt, 3'b111} : 4'b0000;
      DONE:    en_d = phase_d ? 4'b1111 : 4'b0000;
      default: en_d = 4'b1111;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SET;
      presc_q   <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      en_q      <= 4'b1111;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      en_q      <= en_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign {enable_3, enable_2, enable_1, enable_0} = en_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
